mips_decode_alu: RTL and testbench
==================================

# mips_decode_alu

Single-cycle MIPS decode-and-execute slice: main control decode of the opcode, ALU-control decode of funct, immediate extension, ALU operand-B selection and a 32-bit ALU with zero/overflow flags. It sits between register-file read and the memory/write-back stages of the MIPS datapath. All outputs are registered once, an EX/MEM-style boundary, so results appear one clock after the inputs are presented.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears every output register.
- stall  in  1  when high, output registers hold their values.
- instr  in  32  instruction word (opcode [31:26], rt [20:16], rd [15:11], imm [15:0], funct [5:0]).
- rs_data  in  32  register-file value of rs; ALU operand A.
- rt_data  in  32  register-file value of rt; operand B for R-type/beq, store data.
- alu_result  out  32  registered ALU result.
- zero  out  1  registered; 1 iff the ALU result is 0.
- overflow  out  1  registered; signed overflow of add/sub, else 0.
- branch_taken  out  1  registered branch AND zero.
- write_reg  out  5  registered destination: rd if RegDst else rt.
- store_data  out  32  registered copy of rt_data.
- reg_write, mem_read, mem_write, mem_to_reg, branch, jump  out  1 each  registered control bits.
- alu_ctl  out  4  registered ALU control code.

## Operation
- Main control, opcode to {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump, SignZero}:
  - 000000 R-type: 1,0,0,1,0,0,0,10,0,0.
  - 100011 lw: 0,1,1,1,1,0,0,00,0,0.
  - 101011 sw: 0,1,0,0,0,1,0,00,0,0.
  - 000100 beq: 0,0,0,0,0,0,1,01,0,0.
  - 001000 addi: 0,1,0,1,0,0,0,00,0,0.
  - 001101 ori: 0,1,0,1,0,0,0,11,0,1.
  - 000010 j: all 0 except Jump=1.
  - Any other opcode: all bits 0, ALUOp 00; a no-op that writes nothing.
- Immediate: SignZero=0 sign-extends imm[15] into [31:16]; SignZero=1 zero-extends.
- Operand B mux: ALUSrc=0 selects rt_data; ALUSrc=1 selects the extended immediate.
- ALU control: ALUOp 00 gives add (0010); 01 gives sub (0110); 11 gives OR (0001); 10 decodes funct:
  - 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001.
  - 100110 xor 0011, 100111 nor 1100, 101010 slt 0111.
  - Other funct values give 1111.
- ALU per alu_ctl:
  - AND, OR, XOR, NOR bitwise.
  - add/sub modulo 2^32.
  - slt gives 1 if A < B as signed, else 0.
  - 1111 gives 0.
- Overflow, add: A and B share a sign and the result sign differs. Sub: A and B differ in sign and the result sign differs from A. All other ops: 0.
- zero is computed on the final 32-bit result for every op.

## Timing
- Decode and ALU are purely combinational from instr, rs_data and rt_data.
- All outputs load on the rising clk edge when stall=0; latency is exactly 1 cycle.
- stall=1: every output holds its value.
- reset asserted, at any time including mid-stream: all outputs are 0 immediately, with no clock edge needed. Reset takes priority over stall.
- First capture happens on the first rising edge after reset deasserts.
- Back-to-back instructions: one new result per cycle, no bubbles.

## Test plan
- R-type add (funct 100000), rs_data=5, rt_data=7, rd=3 -> next cycle alu_result=12, write_reg=3, reg_write=1, zero=0, overflow=0.
- R-type sub, rs_data=0x80000000, rt_data=1 -> alu_result=0x7FFFFFFF, overflow=1. Same test with slt, rs_data=0xFFFFFFFF, rt_data=1 -> alu_result=1.
- lw, rt=8, imm=0xFFFC, rs_data=100 -> alu_result=96, mem_read=1, mem_to_reg=1, reg_write=1, write_reg=8. sw with the same fields -> mem_write=1, reg_write=0, store_data=rt_data.
- beq, rs_data=rt_data=42 -> zero=1, branch_taken=1, reg_write=0. Same test with rt_data=43 -> zero=0, branch_taken=0.
- ori, imm=0xFFFF, rs_data=0 -> alu_result=0x0000FFFF. addi, imm=0xFFFF, rs_data=0 -> alu_result=0xFFFFFFFF.
- Undefined opcode 111111 -> all control outputs 0. With stall=1 across two edges, outputs are unchanged. Reset pulsed between edges -> outputs 0 at once, and the next edge after release captures the current inputs.

Source files
------------

// File: rtl/mips_decode_alu.sv
// Single-cycle MIPS decode/execute slice: main + ALU-control decode, immediate
// extension, operand-B select and 32-bit ALU, all outputs registered once.
module mips_decode_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow,
  output logic        branch_taken,
  output logic [4:0]  write_reg,
  output logic [31:0] store_data,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic [3:0]  alu_ctl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_NONE = 4'b1111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       sign_zero;
  } ctrl_t;

  logic [5:0]  opcode;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [15:0] imm;
  logic [5:0]  funct;
  logic        unused_rs_idx;

  assign opcode        = instr[31:26];
  assign rt_idx        = instr[20:16];
  assign rd_idx        = instr[15:11];
  assign imm           = instr[15:0];
  assign funct         = instr[5:0];
  assign unused_rs_idx = ^instr[25:21];

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = 2'b01;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b11;
        ctrl.sign_zero = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  logic [31:0] imm_ext;
  logic [31:0] op_b;

  assign imm_ext = ctrl.sign_zero ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign op_b    = ctrl.alu_src ? imm_ext : rt_data;

  logic [3:0] ctl;

  always_comb begin
    ctl = CTL_ADD;
    unique case (ctrl.alu_op)
      2'b00: ctl = CTL_ADD;
      2'b01: ctl = CTL_SUB;
      2'b11: ctl = CTL_OR;
      2'b10: begin
        unique case (funct)
          6'b100000: ctl = CTL_ADD;
          6'b100010: ctl = CTL_SUB;
          6'b100100: ctl = CTL_AND;
          6'b100101: ctl = CTL_OR;
          6'b100110: ctl = CTL_XOR;
          6'b100111: ctl = CTL_NOR;
          6'b101010: ctl = CTL_SLT;
          default:   ctl = CTL_NONE;
        endcase
      end
      default: ctl = CTL_ADD;
    endcase
  end

  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt_signed;
  logic [31:0] result;
  logic        ovf;

  assign sum       = rs_data + op_b;
  assign diff      = rs_data - op_b;
  assign lt_signed = $signed(rs_data) < $signed(op_b);

  // Overflow only exists for add/sub; every other op reports 0.
  always_comb begin
    result = 32'h0000_0000;
    ovf    = 1'b0;
    unique case (ctl)
      CTL_AND: result = rs_data & op_b;
      CTL_OR:  result = rs_data | op_b;
      CTL_XOR: result = rs_data ^ op_b;
      CTL_NOR: result = ~(rs_data | op_b);
      CTL_ADD: begin
        result = sum;
        ovf    = (rs_data[31] == op_b[31]) && (sum[31] != rs_data[31]);
      end
      CTL_SUB: begin
        result = diff;
        ovf    = (rs_data[31] != op_b[31]) && (diff[31] != rs_data[31]);
      end
      CTL_SLT: result = {31'b0, lt_signed};
      default: result = 32'h0000_0000;
    endcase
  end

  logic [31:0] alu_result_d, alu_result_q;
  logic        zero_d, zero_q;
  logic        overflow_d, overflow_q;
  logic        branch_taken_d, branch_taken_q;
  logic [4:0]  write_reg_d, write_reg_q;
  logic [31:0] store_data_d, store_data_q;
  logic        reg_write_d, reg_write_q;
  logic        mem_read_d, mem_read_q;
  logic        mem_write_d, mem_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic        branch_d, branch_q;
  logic        jump_d, jump_q;
  logic [3:0]  alu_ctl_d, alu_ctl_q;

  // Hold is folded into the next-state so the flops only see reset and load.
  always_comb begin
    alu_result_d   = alu_result_q;
    zero_d         = zero_q;
    overflow_d     = overflow_q;
    branch_taken_d = branch_taken_q;
    write_reg_d    = write_reg_q;
    store_data_d   = store_data_q;
    reg_write_d    = reg_write_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    branch_d       = branch_q;
    jump_d         = jump_q;
    alu_ctl_d      = alu_ctl_q;
    if (!stall) begin
      alu_result_d   = result;
      zero_d         = (result == 32'h0000_0000);
      overflow_d     = ovf;
      branch_taken_d = ctrl.branch & (result == 32'h0000_0000);
      write_reg_d    = ctrl.reg_dst ? rd_idx : rt_idx;
      store_data_d   = rt_data;
      reg_write_d    = ctrl.reg_write;
      mem_read_d     = ctrl.mem_read;
      mem_write_d    = ctrl.mem_write;
      mem_to_reg_d   = ctrl.mem_to_reg;
      branch_d       = ctrl.branch;
      jump_d         = ctrl.jump;
      alu_ctl_d      = ctl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q   <= '0;
      zero_q         <= 1'b0;
      overflow_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      write_reg_q    <= '0;
      store_data_q   <= '0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      alu_ctl_q      <= '0;
    end else begin
      alu_result_q   <= alu_result_d;
      zero_q         <= zero_d;
      overflow_q     <= overflow_d;
      branch_taken_q <= branch_taken_d;
      write_reg_q    <= write_reg_d;
      store_data_q   <= store_data_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
      alu_ctl_q      <= alu_ctl_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign zero         = zero_q;
  assign overflow     = overflow_q;
  assign branch_taken = branch_taken_q;
  assign write_reg    = write_reg_q;
  assign store_data   = store_data_q;
  assign reg_write    = reg_write_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_to_reg   = mem_to_reg_q;
  assign branch       = branch_q;
  assign jump         = jump_q;
  assign alu_ctl      = alu_ctl_q;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Bench for mips_decode_alu: hand-derived vector table, stall/reset sequences,
// and random instructions checked against an arithmetic reference model.
module tb_mips_decode_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] alu_result;
  logic        zero, overflow, branch_taken;
  logic [4:0]  write_reg;
  logic [31:0] store_data;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump;
  logic [3:0]  alu_ctl;

  mips_decode_alu dut (
    .clk(clk), .reset(reset), .stall(stall), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_result(alu_result),
    .zero(zero), .overflow(overflow), .branch_taken(branch_taken),
    .write_reg(write_reg), .store_data(store_data), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .alu_ctl(alu_ctl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        bt;
    logic [4:0]  wr;
    logic [31:0] sd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        jp;
    logic [3:0]  ctl;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    out_t        exp;
  } vec_t;

  out_t got;
  assign got = {alu_result, zero, overflow, branch_taken, write_reg, store_data,
                reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_ctl};

  int   n_vec = 0;
  int   n_err = 0;
  out_t last_exp = '0;

  function automatic out_t mk_out(input logic [31:0] res, input logic z, input logic ov,
                                  input logic bt, input logic [4:0] wr, input logic [31:0] sd,
                                  input logic rw, input logic mr, input logic mw,
                                  input logic m2r, input logic br, input logic jp,
                                  input logic [3:0] ctl);
    out_t o;
    o = {res, z, ov, bt, wr, sd, rw, mr, mw, m2r, br, jp, ctl};
    return o;
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] fn);
    return {6'b000000, 5'd1, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, 5'd2, rt, imm};
  endfunction

  // Reference model: mnemonic-level decode, results from 64-bit integer arithmetic.
  function automatic out_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b);
    out_t        o;
    string       op;
    logic [31:0] bsel;
    logic [15:0] imm;
    longint      sa, sb, s;
    o    = '0;
    imm  = ins[15:0];
    op   = "add";
    bsel = b;
    o.wr = ins[20:16];
    case (ins[31:26])
      6'b000000: begin
        o.rw = 1'b1;
        o.wr = ins[15:11];
        case (ins[5:0])
          6'h20: op = "add";
          6'h22: op = "sub";
          6'h24: op = "and";
          6'h25: op = "or";
          6'h26: op = "xor";
          6'h27: op = "nor";
          6'h2a: op = "slt";
          default: op = "none";
        endcase
      end
      6'b100011: begin o.rw = 1'b1; o.mr = 1'b1; o.m2r = 1'b1; bsel = {{16{imm[15]}}, imm}; end
      6'b101011: begin o.mw = 1'b1; bsel = {{16{imm[15]}}, imm}; end
      6'b000100: begin o.br = 1'b1; op = "sub"; end
      6'b001000: begin o.rw = 1'b1; bsel = {{16{imm[15]}}, imm}; end
      6'b001101: begin o.rw = 1'b1; op = "or"; bsel = {16'h0000, imm}; end
      6'b000010: o.jp = 1'b1;
      default: ;
    endcase
    sa = $signed(a);
    sb = $signed(bsel);
    case (op)
      "add": begin s = sa + sb; o.res = s[31:0]; o.ovf = (s != longint'($signed(s[31:0]))); o.ctl = 4'd2; end
      "sub": begin s = sa - sb; o.res = s[31:0]; o.ovf = (s != longint'($signed(s[31:0]))); o.ctl = 4'd6; end
      "and": begin o.res = a & bsel;    o.ctl = 4'd0;  end
      "or":  begin o.res = a | bsel;    o.ctl = 4'd1;  end
      "xor": begin o.res = a ^ bsel;    o.ctl = 4'd3;  end
      "nor": begin o.res = ~(a | bsel); o.ctl = 4'd12; end
      "slt": begin o.res = (sa < sb) ? 32'd1 : 32'd0; o.ctl = 4'd7; end
      default: begin o.res = 32'd0; o.ctl = 4'd15; end
    endcase
    o.zero = (o.res == 32'd0);
    o.bt   = o.br && o.zero;
    o.sd   = b;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (res %h/%h wr %0d/%0d ctl %h/%h)", name, got, exp,
               got.res, exp.res, got.wr, exp.wr, got.ctl, exp.ctl);
    end
    last_exp = exp;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr   = ins;
    rs_data = a;
    rt_data = b;
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] edge_v [5];
    edge_v = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(3) == 0) return edge_v[$urandom_range(4)];
    return $urandom();
  endfunction

  vec_t tbl[$];

  initial begin
    logic [5:0]  ops [7];
    logic [5:0]  fns [7];
    logic [31:0] r, a, b, ins;
    logic [5:0]  op, fn;
    out_t        exp;

    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0d, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

    tbl.push_back('{"add",      mk_r(5'd2, 5'd3, 6'h20), 32'd5, 32'd7,
      mk_out(32'd12, 0, 0, 0, 5'd3, 32'd7, 1, 0, 0, 0, 0, 0, 4'b0010)});
    tbl.push_back('{"sub_ovf",  mk_r(5'd2, 5'd4, 6'h22), 32'h8000_0000, 32'd1,
      mk_out(32'h7FFF_FFFF, 0, 1, 0, 5'd4, 32'd1, 1, 0, 0, 0, 0, 0, 4'b0110)});
    tbl.push_back('{"slt",      mk_r(5'd2, 5'd5, 6'h2a), 32'hFFFF_FFFF, 32'd1,
      mk_out(32'd1, 0, 0, 0, 5'd5, 32'd1, 1, 0, 0, 0, 0, 0, 4'b0111)});
    tbl.push_back('{"lw",       mk_i(6'h23, 5'd8, 16'hFFFC), 32'd100, 32'h1234,
      mk_out(32'd96, 0, 0, 0, 5'd8, 32'h1234, 1, 1, 0, 1, 0, 0, 4'b0010)});
    tbl.push_back('{"sw",       mk_i(6'h2b, 5'd8, 16'hFFFC), 32'd100, 32'h1234,
      mk_out(32'd96, 0, 0, 0, 5'd8, 32'h1234, 0, 0, 1, 0, 0, 0, 4'b0010)});
    tbl.push_back('{"beq_eq",   mk_i(6'h04, 5'd9, 16'h0003), 32'd42, 32'd42,
      mk_out(32'd0, 1, 0, 1, 5'd9, 32'd42, 0, 0, 0, 0, 1, 0, 4'b0110)});
    tbl.push_back('{"beq_ne",   mk_i(6'h04, 5'd9, 16'h0003), 32'd42, 32'd43,
      mk_out(32'hFFFF_FFFF, 0, 0, 0, 5'd9, 32'd43, 0, 0, 0, 0, 1, 0, 4'b0110)});
    tbl.push_back('{"ori",      mk_i(6'h0d, 5'd10, 16'hFFFF), 32'd0, 32'd0,
      mk_out(32'h0000_FFFF, 0, 0, 0, 5'd10, 32'd0, 1, 0, 0, 0, 0, 0, 4'b0001)});
    tbl.push_back('{"addi",     mk_i(6'h08, 5'd10, 16'hFFFF), 32'd0, 32'd0,
      mk_out(32'hFFFF_FFFF, 0, 0, 0, 5'd10, 32'd0, 1, 0, 0, 0, 0, 0, 4'b0010)});
    tbl.push_back('{"add_ovf",  mk_r(5'd2, 5'd6, 6'h20), 32'h7FFF_FFFF, 32'd1,
      mk_out(32'h8000_0000, 0, 1, 0, 5'd6, 32'd1, 1, 0, 0, 0, 0, 0, 4'b0010)});
    tbl.push_back('{"nor",      mk_r(5'd2, 5'd7, 6'h27), 32'd0, 32'd0,
      mk_out(32'hFFFF_FFFF, 0, 0, 0, 5'd7, 32'd0, 1, 0, 0, 0, 0, 0, 4'b1100)});
    tbl.push_back('{"bad_funct", mk_r(5'd2, 5'd7, 6'h00), 32'd9, 32'd9,
      mk_out(32'd0, 1, 0, 0, 5'd7, 32'd9, 1, 0, 0, 0, 0, 0, 4'b1111)});
    tbl.push_back('{"j",        mk_i(6'h02, 5'd0, 16'h0000), 32'd1, 32'd2,
      mk_out(32'd3, 0, 0, 0, 5'd0, 32'd2, 0, 0, 0, 0, 0, 1, 4'b0010)});
    tbl.push_back('{"undef_op", mk_i(6'h3f, 5'd11, 16'h0000), 32'd3, 32'd4,
      mk_out(32'd7, 0, 0, 0, 5'd11, 32'd4, 0, 0, 0, 0, 0, 0, 4'b0010)});

    // Reset with nonzero inputs present: outputs must stay cleared across edges.
    drive(mk_r(5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
    #2 reset = 1'b1;
    #1 check("reset_async", '0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", '0);
    @(negedge clk) reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk) drive(tbl[i].ins, tbl[i].a, tbl[i].b);
      @(posedge clk);
      #1 check(tbl[i].name, tbl[i].exp);
    end

    // Stall across two edges with changing inputs, then release.
    @(negedge clk) begin stall = 1'b1; drive(mk_r(5'd1, 5'd2, 6'h26), 32'hF0F0, 32'h0FF0); end
    @(posedge clk);
    #1 check("stall_1", last_exp);
    @(negedge clk) drive(mk_i(6'h0d, 5'd12, 16'h00F0), 32'h0F00, 32'h5);
    @(posedge clk);
    #1 check("stall_2", last_exp);
    @(negedge clk) stall = 1'b0;
    @(posedge clk);
    #1 check("stall_release",
             mk_out(32'h0000_0FF0, 0, 0, 0, 5'd12, 32'h5, 1, 0, 0, 0, 0, 0, 4'b0001));

    // Mid-stream reset between edges, asserted together with stall.
    @(negedge clk) drive(mk_r(5'd2, 5'd3, 6'h24), 32'hFF00, 32'h0FF0);
    stall = 1'b1;
    reset = 1'b1;
    #1 check("reset_mid", '0);
    @(negedge clk) begin reset = 1'b0; stall = 1'b0; end
    @(posedge clk);
    #1 check("after_reset",
             mk_out(32'h0000_0F00, 0, 0, 0, 5'd3, 32'h0FF0, 1, 0, 0, 0, 0, 0, 4'b0000));

    // Random back-to-back traffic with occasional stalls.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom();
      op = ($urandom_range(7) == 0) ? r[31:26] : ops[$urandom_range(6)];
      fn = ($urandom_range(7) == 0) ? r[5:0] : fns[$urandom_range(6)];
      ins = {op, r[25:6], fn};
      a = pick_val();
      b = ($urandom_range(5) == 0) ? a : pick_val();
      @(negedge clk) begin
        drive(ins, a, b);
        stall = ($urandom_range(7) == 0);
      end
      exp = stall ? last_exp : model(ins, a, b);
      @(posedge clk);
      #1 check("random", exp);
    end
    @(negedge clk) stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
